// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI encodings, read-master state type and size helper
package axi_pkg;
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} rd_state_t;
  function automatic logic [2:0] axi_size(input int dw);
    return 3'($clog2(dw / 8));
  endfunction
endpackage

// File: rtl/axi_read_master_if.sv
// axi_read_master_if: AXI4 AR/R channel bundle with master/slave views
interface axi_read_master_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDRESS_WIDTH-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arvalid;
  logic arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0] rresp;
  logic rlast;
  logic rvalid;
  logic rready;
  modport master(output araddr, arlen, arsize, arburst, arvalid, rready,
                 input arready, rdata, rresp, rlast, rvalid);
  modport slave(input araddr, arlen, arsize, arburst, arvalid, rready,
                output arready, rdata, rresp, rlast, rvalid);
endinterface

// File: rtl/axi_read_master.sv
// axi_read_master: single-outstanding INCR burst reader streaming R beats to a valid/ready port
module axi_read_master
  import axi_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [7:0]               cmd_len,
  axi_read_master_if.master        axi,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     done,
  output logic [1:0]               done_err,
  output logic                     busy
);
  localparam logic [2:0] SIZE = axi_size(DATA_WIDTH);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = {ADDRESS_WIDTH{1'b1}} << SIZE;
  rd_state_t state;
  logic [8:0] beat_cnt;
  logic [1:0] err;
  logic [1:0] err_nxt;
  logic last_beat;
  logic beat;
  assign last_beat = beat_cnt == {1'b0, axi.arlen};
  assign beat = axi.rvalid && axi.rready;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign axi.arsize = SIZE;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.rready = state == DATA && out_ready;
  assign out_valid = state == DATA && axi.rvalid;
  assign out_data = axi.rdata;
  assign out_last = state == DATA && last_beat;
  // completion follows the expected count; rlast only feeds the mismatch flag
  assign err_nxt = err | {axi.rlast != last_beat,
                          axi.rresp == AXI_RESP_SLVERR || axi.rresp == AXI_RESP_DECERR};
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      state <= IDLE;
      axi.arvalid <= 1'b0;
      axi.araddr <= '0;
      axi.arlen <= '0;
      beat_cnt <= '0;
      err <= '0;
      done <= 1'b0;
      done_err <= '0;
    end else begin
      done <= 1'b0;
      done_err <= '0;
      case (state)
        IDLE: if (cmd_valid) begin
          axi.araddr <= cmd_addr & ADDR_MASK;
          axi.arlen <= cmd_len;
          err <= '0;
          beat_cnt <= '0;
          axi.arvalid <= 1'b1;
          state <= ADDR;
        end
        ADDR: if (axi.arready) begin
          axi.arvalid <= 1'b0;
          state <= DATA;
        end
        DATA: if (beat) begin
          beat_cnt <= beat_cnt + 9'd1;
          err <= err_nxt;
          if (last_beat) begin
            state <= RESP;
            done <= 1'b1;
            done_err <= err_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/axi_read_master.md
Name: axi_read_master

Overview:
AXI4 read-channel initiator that drives the AR/R ports of axi_slave_ram and other AXI slaves. It accepts a single burst command (start address, beat count) on a valid/ready command port and issues one INCR burst on AR. It streams returned R beats to a valid/ready output with backpressure, then reports completion and error status. It handles one outstanding burst at a time.

Parameters:
ADDRESS_WIDTH, 8, width of cmd_addr and araddr.
DATA_WIDTH, 32, width of rdata/out_data; must be 8, 16, 32, 64 or 128.

Ports:
aclk  in  1  clock; all logic on rising edge.
areset  in  1  asynchronous, active-high reset.
cmd_valid  in  1  burst request valid.
cmd_ready  out  1  block idle and able to accept a command.
cmd_addr  in  ADDRESS_WIDTH  byte start address.
cmd_len  in  8  beats minus one (AXI arlen encoding; 0 = 1 beat, 255 = 256 beats).
araddr  out  ADDRESS_WIDTH  read address.
arlen  out  8  burst length minus one.
arsize  out  3  log2(DATA_WIDTH/8), constant.
arburst  out  2  constant 2'b01 (INCR).
arvalid  out  1  address valid.
arready  in  1  slave accepts address.
rdata  in  DATA_WIDTH  read data.
rresp  in  2  beat response.
rlast  in  1  slave marks final beat.
rvalid  in  1  beat valid.
rready  out  1  master accepts beat.
out_data  out  DATA_WIDTH  forwarded beat.
out_last  out  1  final expected beat of the burst.
out_valid  out  1  forwarded beat valid.
out_ready  in  1  consumer accepts beat.
done  out  1  one-cycle completion pulse.
done_err  out  2  bit0: any rresp[1]=1 (SLVERR/DECERR); bit1: rlast mismatch. Valid with done.
busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, arvalid=0, araddr=0, arlen=0, beat_cnt=0, err=0, done=0, done_err=0. rready=0 and out_valid=0 follow from IDLE.
- States: IDLE, ADDR, DATA, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch araddr = cmd_addr with the low log2(DATA_WIDTH/8) bits cleared, latch arlen = cmd_len, clear err and beat_cnt, go to ADDR. arvalid rises in the cycle after cmd acceptance.
- ADDR: arvalid=1; araddr/arlen held stable. On arvalid&&arready go to DATA and drop arvalid the next cycle. arvalid never depends on arready.
- DATA: rready = out_ready; out_valid = rvalid; out_data = rdata (combinational pass-through, zero latency). out_last = (beat_cnt == arlen).
- A beat is handshaked when rvalid&&rready.
- On each handshaked beat: beat_cnt += 1. If rresp[1], set err[0]. If rlast != (beat_cnt == arlen), set err[1].
- On the handshaked beat with beat_cnt == arlen, go to RESP. Completion is decided by the expected count only; an early rlast does not end the burst.
- RESP: done=1 and done_err=err for exactly one cycle, then IDLE. cmd_ready=0 in RESP, so a back-to-back command is accepted one cycle after done.
- Outside DATA: rready=0 and out_valid=0. Beats arriving in IDLE/ADDR are never consumed.
- beat_cnt is 9 bits, so len=255 (256 beats) does not wrap before completion.
- No 4 KB boundary check: callers must not cross a 4 KB boundary. With ADDRESS_WIDTH <= 12 this cannot happen.
- Reset mid-burst: return to IDLE at once; no done pulse. Slave recovery is handled by resetting the slave together with this block.
- rresp=EXOKAY (2'b01) is treated as no error.

Decomposition:
- Shared package axi_pkg holds: AXI_BURST_FIXED/INCR/WRAP encodings; AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR; the rd_state_t enum (IDLE, ADDR, DATA, RESP); a function that computes the size code from DATA_WIDTH.
- No sub-module: the FSM, counter and pass-through are small enough to stay flat.

Test Plan:
- Single beat: cmd_addr=8'h13, cmd_len=0, slave arready=1 → araddr=8'h10, arlen=0, arsize=3'd2, arburst=2'b01, arvalid high exactly one cycle. One beat 32'hDEADBEEF with rlast=1 → out_data=DEADBEEF, out_last=1, done pulses one cycle after the beat with done_err=0.
- 4-beat burst against axi_slave_ram preloaded with mem[0x20+4i]=i: cmd_addr=8'h20, cmd_len=3 → out_data sequence 0,1,2,3; out_last only on the 4th beat; done_err=0.
- Backpressure: same 4-beat burst with out_ready toggling 1,0,0,1,... → rready mirrors out_ready; no beat lost or duplicated; beat count is 4.
- Errors: beat 1 with rresp=2'b10, then rlast=1 on beat 2 of a 4-beat burst → transfer runs to 4 beats; done_err=2'b11.
- arready held low 5 cycles → arvalid and araddr stable throughout; rready=0 until the AR handshake.
- Reset mid-DATA: after 2 of 4 beats, assert areset → busy=0, arvalid=0, rready=0 with no clock edge needed; no done pulse. A new command afterwards completes normally.
